credit_counter: RTL and testbench

- Producer side of the credit display path: holds the player credit balance and drives the digit that the credit display renders.
- Debounces the raw coin button and adds credits on each accepted press.
- Serves start-game requests from the game FSM by consuming one credit and answering with a one-cycle grant or deny pulse.
- Output `creditNumber` connects directly to the number bitmap input of the credit display.

---
 rtl/credit_counter.sv | 157 +++++++++++++++
 tb/tb_credit_counter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_counter.sv
// credit_counter
//   Producer side of the credit display path. Synchronizes and debounces the
//   raw coin button, adds credits per accepted press (saturating at
//   MAX_CREDITS), and serves start-game requests by consuming one credit and
//   answering with a one-cycle grant or deny pulse.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   coinIn        in   raw asynchronous coin button, 1 = pressed
//   startRequest  in   level from the game FSM, rising edge is a request
//   creditNumber  out  [3:0] current balance, registered
//   noCredit      out  1 when creditNumber == 0, registered
//   coinAccepted  out  one-cycle pulse per accepted coin press
//   startGrant    out  one-cycle pulse, a credit was consumed
//   startDenied   out  one-cycle pulse, request arrived with zero balance
module credit_counter #(
   parameter int MAX_CREDITS      = 9,
   parameter int CREDITS_PER_COIN = 1,
   parameter int DEBOUNCE_CYCLES  = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coinIn,
   input  logic       startRequest,
   output logic [3:0] creditNumber,
   output logic       noCredit,
   output logic       coinAccepted,
   output logic       startGrant,
   output logic       startDenied
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } coin_state_e;

   // Clamp the 6-bit running sum to the display ceiling.
   function automatic logic [3:0] sat_credit(input logic [5:0] s);
      if (s > 6'(MAX_CREDITS)) return 4'(MAX_CREDITS);
      else                     return s[3:0];
   endfunction

   logic              sync1_q;
   logic              sync2_q;
   logic              coinS;
   coin_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              startReq_q;
   logic              startEdge;
   logic              consume;
   logic [3:0]        credit_q, credit_d;
   logic              noCredit_q;
   logic              grant_q, deny_q;
   logic [5:0]        sum;

   // ---- stage: two-flop synchronizer on the raw button
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= coinIn;
         sync2_q <= sync1_q;
      end
   end

   assign coinS = sync2_q;

   // ---- stage: coin debounce FSM (state register)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the counter measures how long coinS has held its new level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (coinS) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!coinS)                state_d = IDLE;
            else if (cnt_q == CNT_LAST) state_d = HELD;
            else                       cnt_d   = cnt_q + CNT_W'(1);
         end
         HELD: begin
            if (!coinS) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (coinS)                 state_d = HELD;
            else if (cnt_q == CNT_LAST) state_d = IDLE;
            else                       cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Output: the accept pulse is the last confirming cycle of PRESS_WAIT,
   // so it lasts exactly the cycle before the move to HELD.
   always_comb begin
      coinAccepted = (state_q == PRESS_WAIT) && coinS && (cnt_q == CNT_LAST);
   end

   // ---- stage: start edge detect and balance update
   assign startEdge = startRequest & ~startReq_q;
   // Decision uses the pre-update balance, so a coin arriving in the same
   // cycle cannot fund a request made at zero balance.
   assign consume   = startEdge & (credit_q != 4'd0);

   always_comb begin
      sum      = {2'b00, credit_q}
               + (coinAccepted ? 6'(CREDITS_PER_COIN) : 6'd0)
               - {5'd0, consume};
      credit_d = sat_credit(sum);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         startReq_q <= 1'b0;
         credit_q   <= 4'd0;
         noCredit_q <= 1'b1;
         grant_q    <= 1'b0;
         deny_q     <= 1'b0;
      end else begin
         startReq_q <= startRequest;
         credit_q   <= credit_d;
         noCredit_q <= (credit_d == 4'd0);
         grant_q    <= consume;
         deny_q     <= startEdge & (credit_q == 4'd0);
      end
   end

   assign creditNumber = credit_q;
   assign noCredit     = noCredit_q;
   assign startGrant   = grant_q;
   assign startDenied  = deny_q;

endmodule

// File: tb/tb_credit_counter.sv
module tb_credit_counter;

   localparam int D   = 4;
   localparam int MAX = 9;
   localparam int CPC = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       coinIn;
   logic       startRequest;
   logic [3:0] creditNumber;
   logic       noCredit;
   logic       coinAccepted;
   logic       startGrant;
   logic       startDenied;

   credit_counter #(
      .MAX_CREDITS     (MAX),
      .CREDITS_PER_COIN(CPC),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .coinIn      (coinIn),
      .startRequest(startRequest),
      .creditNumber(creditNumber),
      .noCredit    (noCredit),
      .coinAccepted(coinAccepted),
      .startGrant  (startGrant),
      .startDenied (startDenied)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: coin accepted when the synced level has differed from
   // the debounced level for D+1 consecutive cycles; balance follows plain
   // arithmetic with a ceiling.
   int m_bal      = 0;
   bit m_grant    = 0;
   bit m_deny     = 0;
   bit m_acc      = 0;
   bit m_deb      = 0;
   int m_run      = 0;
   bit m_samp     = 0;   // coinIn seen at the previous edge
   bit m_coinS    = 0;
   bit m_sreqPrev = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_bal = 0; m_grant = 0; m_deny = 0; m_acc = 0;
         m_deb = 0; m_run = 0; m_samp = 0; m_coinS = 0; m_sreqPrev = 0;
      end else begin
         bit se;
         bit cons;
         int b;
         se          = startRequest && !m_sreqPrev;
         m_sreqPrev  = startRequest;
         cons        = se && (m_bal > 0);
         m_grant     = cons;
         m_deny      = se && (m_bal == 0);
         b           = m_bal + (m_acc ? CPC : 0) - (cons ? 1 : 0);
         m_bal       = (b > MAX) ? MAX : b;
         m_coinS     = m_samp;
         m_samp      = coinIn;
         if (m_coinS != m_deb) m_run++;
         else                  m_run = 0;
         m_acc = 0;
         if (m_run == D + 1) begin
            m_acc = !m_deb;
            m_deb = !m_deb;
            m_run = 0;
         end
      end
   end

   bit mon_en  = 0;
   int acc_cnt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("creditNumber", int'(creditNumber), m_bal);
         chk("noCredit",     int'(noCredit),     int'(m_bal == 0));
         chk("coinAccepted", int'(coinAccepted), int'(m_acc));
         chk("startGrant",   int'(startGrant),   int'(m_grant));
         chk("startDenied",  int'(startDenied),  int'(m_deny));
         if (coinAccepted) acc_cnt++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int hold, input int gap);
      coinIn = 1'b1;
      step(hold);
      coinIn = 1'b0;
      step(gap);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      coinIn = 1'b0;
      startRequest = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      int a0;
      int rem;
      reset = 1'b1;
      coinIn = 1'b0;
      startRequest = 1'b0;
      step(2);
      mon_en = 1;
      step(1);
      reset = 1'b0;

      // idle after reset, then a start request at zero balance
      step(20);
      chk("rst_credit",   int'(creditNumber), 0);
      chk("rst_noCredit", int'(noCredit), 1);
      chk("rst_pulses",   int'({coinAccepted, startGrant, startDenied}), 0);
      startRequest = 1'b1;
      step(1);
      chk("deny_pulse", int'(startDenied), 1);
      step(1);
      chk("deny_once", int'(startDenied), 0);
      chk("deny_bal",  int'(creditNumber), 0);
      startRequest = 1'b0;
      step(2);

      // one long press: pulse 6 cycles after the rise, credit the cycle after
      a0 = acc_cnt;
      coinIn = 1'b1;
      step(5);
      chk("coin_lat5", int'(coinAccepted), 0);
      step(1);
      chk("coin_lat6", int'(coinAccepted), 1);
      step(1);
      chk("coin_credit1", int'(creditNumber), 1);
      chk("coin_noCredit", int'(noCredit), 0);
      step(13);
      coinIn = 1'b0;
      step(10);
      chk("coin_one_pulse", acc_cnt - a0, 1);
      repeat (3) press(10, 10);
      chk("coin_credit4", int'(creditNumber), 4);

      // glitches shorter than the debounce window
      a0 = acc_cnt;
      repeat (10) begin
         coinIn = 1'b1; step(2);
         coinIn = 1'b0; step(2);
      end
      step(10);
      chk("glitch_none", acc_cnt - a0, 0);
      chk("glitch_credit", int'(creditNumber), 4);

      // saturation
      a0 = acc_cnt;
      repeat (12) press(8, 8);
      chk("sat_credit", int'(creditNumber), 9);
      chk("sat_pulses", acc_cnt - a0, 12);

      // grants from balance 3
      do_reset();
      repeat (3) press(8, 8);
      chk("bal3", int'(creditNumber), 3);
      startRequest = 1'b1;
      step(10);
      chk("grant_credit2", int'(creditNumber), 2);
      startRequest = 1'b0;
      step(2);
      startRequest = 1'b1;
      step(1);
      chk("grant2_pulse", int'(startGrant), 1);
      chk("grant2_credit1", int'(creditNumber), 1);
      step(2);
      startRequest = 1'b0;
      step(2);

      // coin and start together at balance 0
      do_reset();
      step(4);
      coinIn = 1'b1;
      step(6);
      startRequest = 1'b1;
      chk("co0_acc", int'(coinAccepted), 1);
      step(1);
      chk("co0_deny",   int'(startDenied), 1);
      chk("co0_grant",  int'(startGrant), 0);
      chk("co0_credit", int'(creditNumber), 1);
      step(10);
      coinIn = 1'b0;
      startRequest = 1'b0;
      step(8);

      // coin and start together at MAX
      repeat (10) press(8, 8);
      chk("co9_bal", int'(creditNumber), 9);
      coinIn = 1'b1;
      step(6);
      startRequest = 1'b1;
      chk("co9_acc", int'(coinAccepted), 1);
      step(1);
      chk("co9_grant",  int'(startGrant), 1);
      chk("co9_credit", int'(creditNumber), 9);
      step(10);
      coinIn = 1'b0;
      startRequest = 1'b0;
      step(8);

      // reset in the middle of a debounce
      do_reset();
      a0 = acc_cnt;
      coinIn = 1'b1;
      step(4);
      reset = 1'b1;
      coinIn = 1'b0;
      step(1);
      reset = 1'b0;
      step(20);
      chk("rstpw_none", acc_cnt - a0, 0);
      chk("rstpw_credit", int'(creditNumber), 0);

      // randomized traffic against the model
      rem = 0;
      for (int i = 0; i < 4000; i++) begin
         if (rem == 0) begin
            coinIn = ~coinIn;
            rem = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12));
         end else begin
            rem--;
         end
         if ($urandom_range(0, 3) == 0) startRequest = ~startRequest;
         reset = ($urandom_range(0, 499) == 0);
         step(1);
      end
      reset = 1'b0;
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
